// File: rtl/sample_pkg.sv
// Shared constants and state type for the sample RAM write path and the
// playback address counter, so both ends agree on buffer depth.
package sample_pkg;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned DW     = 16;

   localparam logic [ADDR_W-1:0] MAXCOUNT  = 14'd12348;
   localparam logic [DW-1:0]     THRESHOLD = 16'd1024;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      RECORD = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/sample_recorder_abs_threshold.sv
// Trigger detector: |x| with saturation of the most negative code,
// compared against the recording threshold.
module abs_threshold
   import sample_pkg::*;
(
   input  logic [DW-1:0] x,
   output logic          trig
);

   localparam logic [DW-1:0] NEG_MAX = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};

   logic [DW-1:0] mag;

   always_comb begin
      mag = x;
      if (x[DW-1]) begin
         // -32768 has no positive counterpart; clamp instead of wrapping
         mag = (x == NEG_MAX) ? POS_MAX : ('0 - x);
      end
      trig = (mag >= THRESHOLD);
   end

endmodule

// File: rtl/sample_recorder.sv
// One-shot sample recorder: armed by the user, triggered by signal level,
// writes codec samples into the sample RAM and publishes the stored length.
module sample_recorder
   import sample_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              arm,
   input  logic              stop,
   input  logic              sample_valid,
   input  logic [DW-1:0]     sample_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DW-1:0]     wr_data,
   output logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic              full
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state_q,   state_d;
   logic [ADDR_W-1:0] ptr_q,     ptr_d;
   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0]     wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] length_q,  length_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic              full_q,    full_d;

   logic trig;
   logic do_write;

   abs_threshold u_abs_threshold (
      .x    (sample_data),
      .trig (trig)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      length_d  = length_q;
      done_d    = 1'b0;
      full_d    = full_q;
      do_write  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (arm) begin
               state_d = ARMED;
               ptr_d   = '0;
               full_d  = 1'b0;
            end
         end
         ARMED: begin
            if (stop) begin
               state_d = IDLE;
            end else if (sample_valid && trig) begin
               do_write = 1'b1;
            end
         end
         RECORD: begin
            if (sample_valid) begin
               do_write = 1'b1;
            end else if (stop) begin
               state_d  = DONE;
               length_d = ptr_q;
               done_d   = 1'b1;
            end
         end
         DONE: begin
            if (arm) begin
               state_d = ARMED;
               ptr_d   = '0;
               full_d  = 1'b0;
            end
         end
      endcase

      // The triggering write and every RECORD write share one path, so a
      // coincident stop still lands the sample before the session closes.
      if (do_write) begin
         wr_en_d   = 1'b1;
         wr_addr_d = ptr_q;
         wr_data_d = sample_data;
         if (ptr_q == MAXCOUNT) begin
            state_d  = DONE;
            full_d   = 1'b1;
            length_d = MAXCOUNT + ONE;
            done_d   = 1'b1;
         end else if (stop) begin
            state_d  = DONE;
            length_d = ptr_q + ONE;
            done_d   = 1'b1;
         end else begin
            state_d  = RECORD;
            ptr_d    = ptr_q + ONE;
         end
      end

      busy_d = (state_d == ARMED) || (state_d == RECORD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         length_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         full_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         length_q  <= length_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         full_q    <= full_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign length  = length_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign full    = full_q;

endmodule

// File: tb/tb_sample_recorder.sv
// Directed bench for sample_recorder: arming, threshold trigger, stop,
// buffer-full termination, reset during recording and re-arming.
module tb_sample_recorder;

   logic        clk;
   logic        reset;
   logic        arm;
   logic        stop;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        wr_en;
   logic [13:0] wr_addr;
   logic [15:0] wr_data;
   logic [13:0] length;
   logic        busy;
   logic        done;
   logic        full;

   int errors = 0;
   int checks = 0;

   logic [15:0] ram [0:12348];
   int unsigned wr_cnt = 0;
   int unsigned done_cnt = 0;
   int unsigned bad_addr_cnt = 0;
   logic [13:0] last_addr = '0;

   sample_recorder dut (
      .clk          (clk),
      .reset        (reset),
      .arm          (arm),
      .stop         (stop),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .length       (length),
      .busy         (busy),
      .done         (done),
      .full         (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model and event counters, sampled mid-cycle
   always @(negedge clk) begin
      if (wr_en) begin
         wr_cnt++;
         last_addr = wr_addr;
         if (wr_addr <= 14'd12348) ram[wr_addr] = wr_data;
         else bad_addr_cnt++;
      end
      if (done) done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_arm();
      @(negedge clk);
      arm = 1'b1;
      @(posedge clk);
      #1;
      arm = 1'b0;
   endtask

   task automatic pulse_stop();
      @(negedge clk);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
   endtask

   task automatic send(input logic [15:0] d, input logic with_stop);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = d;
      stop         = with_stop;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      stop         = 1'b0;
   endtask

   task automatic send_chk(input string tag, input logic [15:0] d, input logic exp_we,
                           input logic [13:0] exp_addr);
      send(d, 1'b0);
      chk({tag, ".wr_en"}, 32'(wr_en), 32'(exp_we));
      if (exp_we) begin
         chk({tag, ".addr"}, 32'(wr_addr), 32'(exp_addr));
         chk({tag, ".data"}, 32'(wr_data), 32'(d));
      end
   endtask

   initial begin
      int unsigned wr_base;
      int unsigned done_base;
      logic [15:0] patt;

      reset = 1'b1; arm = 1'b1; stop = 1'b0; sample_valid = 1'b0; sample_data = '0;
      repeat (2) @(posedge clk);
      #1;
      arm = 1'b0;

      // 1: reset state, then a loud sample with no arm
      chk("rst.busy",   32'(busy),    32'd0);
      chk("rst.wr_en",  32'(wr_en),   32'd0);
      chk("rst.length", 32'(length),  32'd0);
      chk("rst.done",   32'(done),    32'd0);
      chk("rst.full",   32'(full),    32'd0);
      chk("rst.addr",   32'(wr_addr), 32'd0);
      chk("rst.data",   32'(wr_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      send_chk("t1.idle", 16'h7FFF, 1'b0, 14'd0);
      repeat (2) @(negedge clk);
      chk("t1.wr_cnt", wr_cnt, 32'd0);
      chk("t1.busy", 32'(busy), 32'd0);
      chk("t1.length", 32'(length), 32'd0);

      // 2: sub-threshold samples dropped, exact threshold triggers
      pulse_arm();
      chk("t2.busy_armed", 32'(busy), 32'd1);
      send_chk("t2.s100",  16'd100,  1'b0, 14'd0);
      send_chk("t2.sm200", 16'hFF38, 1'b0, 14'd0);
      send_chk("t2.s1023", 16'd1023, 1'b0, 14'd0);
      chk("t2.busy_still", 32'(busy), 32'd1);
      send_chk("t2.s1024", 16'd1024, 1'b1, 14'd0);
      send_chk("t2.s5",    16'd5,    1'b1, 14'd1);
      send_chk("t2.s7",    16'd7,    1'b1, 14'd2);
      pulse_stop();
      chk("t2.done",   32'(done),   32'd1);
      chk("t2.length", 32'(length), 32'd3);
      chk("t2.full",   32'(full),   32'd0);
      chk("t2.busy",   32'(busy),   32'd0);
      @(posedge clk);
      #1;
      chk("t2.done_pulse", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      chk("t2.wr_cnt",   wr_cnt,   32'd3);
      chk("t2.done_cnt", done_cnt, 32'd1);
      chk("t2.ram2",     32'(ram[2]), 32'd7);

      // 3: saturating trigger, then fill the whole buffer
      wr_base = wr_cnt; done_base = done_cnt;
      pulse_arm();
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = 16'h8000;
      @(posedge clk);
      #1;
      chk("t3.trig_we",   32'(wr_en),   32'd1);
      chk("t3.trig_addr", 32'(wr_addr), 32'd0);
      chk("t3.trig_data", 32'(wr_data), 32'h8000);
      for (int i = 1; i <= 12350; i++) begin
         @(negedge clk);
         sample_data = 16'(i) ^ 16'h5A5A;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t3.wr_cnt",    wr_cnt - wr_base,     32'd12349);
      chk("t3.last_addr", 32'(last_addr),       32'd12348);
      patt = 16'd12348 ^ 16'h5A5A;
      chk("t3.ram_last",  32'(ram[12348]),      32'(patt));
      chk("t3.ram0",      32'(ram[0]),          32'h8000);
      chk("t3.bad_addr",  bad_addr_cnt,         32'd0);
      chk("t3.full",      32'(full),            32'd1);
      chk("t3.length",    32'(length),          32'd12349);
      chk("t3.done_cnt",  done_cnt - done_base, 32'd1);
      chk("t3.busy",      32'(busy),            32'd0);
      chk("t3.wr_en",     32'(wr_en),           32'd0);

      // 4: stop coincident with the 11th sample
      wr_base = wr_cnt;
      pulse_arm();
      chk("t4.full_clr",  32'(full),   32'd0);
      chk("t4.len_keep",  32'(length), 32'd12349);
      send_chk("t4.trig", 16'd2000, 1'b1, 14'd0);
      for (int k = 1; k <= 9; k++) begin
         send_chk("t4.s", 16'(k), 1'b1, 14'(k));
      end
      send(16'd11, 1'b1);
      chk("t4.last_we",   32'(wr_en),   32'd1);
      chk("t4.last_addr", 32'(wr_addr), 32'd10);
      chk("t4.done",      32'(done),    32'd1);
      chk("t4.length",    32'(length),  32'd11);
      chk("t4.full",      32'(full),    32'd0);
      repeat (2) @(negedge clk);
      chk("t4.wr_cnt", wr_cnt - wr_base, 32'd11);

      // 5: reset at ptr=500 discards the session
      wr_base = wr_cnt;
      pulse_arm();
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = 16'hF000;
      for (int j = 1; j <= 499; j++) begin
         @(negedge clk);
         sample_data = 16'(j);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t5.busy",   32'(busy),   32'd0);
      chk("t5.wr_en",  32'(wr_en),  32'd0);
      chk("t5.length", 32'(length), 32'd0);
      chk("t5.full",   32'(full),   32'd0);
      chk("t5.done",   32'(done),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      sample_data = 16'h7FFF;
      repeat (3) @(negedge clk);
      sample_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5.wr_cnt",    wr_cnt - wr_base,   32'd500);
      chk("t5.last_addr", 32'(last_addr),     32'd499);

      // 6: abort from ARMED keeps length; re-record with negative boundary trigger
      pulse_arm();
      send_chk("t6a.trig", 16'd3000, 1'b1, 14'd0);
      send_chk("t6a.s1",   16'd1,    1'b1, 14'd1);
      send_chk("t6a.s2",   16'd2,    1'b1, 14'd2);
      pulse_stop();
      chk("t6a.length", 32'(length), 32'd3);
      done_base = done_cnt + 32'd1;
      pulse_arm();
      chk("t6b.busy",     32'(busy),   32'd1);
      chk("t6b.len_keep", 32'(length), 32'd3);
      pulse_stop();
      chk("t6b.busy_idle", 32'(busy),   32'd0);
      chk("t6b.length",    32'(length), 32'd3);
      chk("t6b.no_done",   32'(done),   32'd0);
      send_chk("t6b.idle_s", 16'h7000, 1'b0, 14'd0);
      pulse_stop();
      chk("t6b.idle_stop", 32'(length), 32'd3);
      repeat (2) @(negedge clk);
      chk("t6b.done_cnt", done_cnt, done_base);
      pulse_arm();
      send_chk("t6c.sm1023", 16'hFC01, 1'b0, 14'd0);
      send_chk("t6c.sm1024", 16'hFC00, 1'b1, 14'd0);
      send_chk("t6c.s9",     16'd9,    1'b1, 14'd1);
      pulse_stop();
      chk("t6c.done",   32'(done),   32'd1);
      chk("t6c.length", 32'(length), 32'd2);
      chk("t6c.full",   32'(full),   32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
